// File: rtl/resource_scheduler.sv
// Round-robin arbiter for one shared resource with a per-owner hold limit.
// The owner is released on done, when it drops its request, or forcibly after MAX_HOLD cycles.
module resource_scheduler #(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout
);
  // state | meaning
  // IDLE  | no owner; grant = 0; winner loaded at next edge if any req
  // OWN   | owner_q holds the resource; cnt_q counts owned cycles from 0
  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [OW-1:0] LAST_INIT = OW'(N_REQ - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d, last_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, timeout_q, armed_q;
  logic             win_found, own_req, own_done;

  // Search upward from the previous winner so requester order rotates.
  always_comb begin
    win_found = 1'b0;
    owner_d   = '0;
    grant_d   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int cand;
      cand = (int'(last_q) + k) % N_REQ;
      if (!win_found && req[cand[OW-1:0]]) begin
        win_found = 1'b1;
        owner_d   = cand[OW-1:0];
      end
    end
    if (win_found) grant_d[owner_d] = 1'b1;
  end

  assign own_req  = req[owner_q];
  assign own_done = done[owner_q];

  // armed_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= LAST_INIT;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (armed_q && win_found) begin
            state_q <= OWN;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= owner_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        OWN: begin
          if (own_done || !own_req || (cnt_q == HOLD_LAST)) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= own_req && !own_done;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_resource_scheduler.sv
// Scoreboard bench for resource_scheduler: a queue-based reference model predicts
// each post-edge output; a monitor pops and compares one entry per clock.
module tb_resource_scheduler;
  localparam int N  = 3;
  localparam int MH = 16;
  localparam int OW = $clog2(N);
  localparam int STARVE_BOUND = (N - 1) * (MH + 1) + 1;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [OW-1:0] owner;
    logic          busy;
    logic          tmo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          busy;
  logic          timeout;

  resource_scheduler #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  bit   mon_en = 0;
  bit   starv_en = 0;
  int   wait_c[N];
  int   max_wait[N];

  // Reference model: the owner index (-1 when free) and how many cycles it has held so far.
  int m_own, m_cnt, m_last;
  bit m_armed;

  // Per-phase observations taken at the falling edge.
  int           runs[$];
  logic [N-1:0] wins[$];
  int           cur_len, tmo_seen;
  logic [N-1:0] prev_g;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    m_own = -1; m_cnt = 0; m_last = N - 1; m_armed = 0;
  endfunction

  function automatic exp_t model_step(logic [N-1:0] r, logic [N-1:0] d);
    exp_t e;
    bit   to;
    to = 0;
    if (m_own < 0) begin
      if (m_armed && r != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (m_own < 0 && r[c]) m_own = c;
        end
        m_last = m_own;
        m_cnt  = 0;
      end
    end else if (d[m_own] || !r[m_own]) begin
      m_own = -1;
    end else if (m_cnt + 1 == MH) begin
      m_own = -1;
      to    = 1;
    end else begin
      m_cnt++;
    end
    m_armed = 1;
    e.grant = '0;
    if (m_own >= 0) e.grant[m_own] = 1'b1;
    e.owner = (m_own >= 0) ? OW'(m_own) : '0;
    e.busy  = (m_own >= 0);
    e.tmo   = to;
    return e;
  endfunction

  function automatic logic [N-1:0] own_bit();
    logic [N-1:0] b;
    b = '0;
    if (m_own >= 0) b[m_own] = 1'b1;
    return b;
  endfunction

  function automatic void clear_obs();
    runs.delete(); wins.delete();
    cur_len = 0; tmo_seen = 0; prev_g = '0;
  endfunction

  // Called at a falling edge: apply inputs, predict, and advance to the next falling edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] d);
    req  = r;
    done = d;
    exp_q.push_back(model_step(r, d));
    @(negedge clk);
    if (grant != '0) cur_len++;
    else if (cur_len > 0) begin runs.push_back(cur_len); cur_len = 0; end
    if (grant != '0 && prev_g == '0) wins.push_back(grant);
    prev_g = grant;
    if (timeout) tmo_seen++;
  endtask

  task automatic do_reset();
    mon_en = 0;
    req = '0; done = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    clear_obs();
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'(exp_q.size()), 32'h1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("owner", 32'(owner), 32'(e.owner));
        check("busy", 32'(busy), 32'(e.busy));
        check("timeout", 32'(timeout), 32'(e.tmo));
      end
      check("grant_onehot0", 32'($onehot0(grant)), 32'h1);
      if (starv_en) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && !grant[i]) wait_c[i]++;
          else wait_c[i] = 0;
          if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r, d;
    clear_obs();
    @(negedge clk);

    // Rotation with done on the third owned cycle; first grant only after the second edge.
    do_reset();
    cycle(3'b111, '0);
    check("first_edge_no_grant", 32'(grant), 32'h0);
    for (int i = 0; i < 20; i++) cycle(3'b111, (m_own >= 0 && m_cnt == 2) ? own_bit() : '0);
    check("rr_win0", 32'(wins[0]), 32'h1);
    check("rr_win1", 32'(wins[1]), 32'h2);
    check("rr_win2", 32'(wins[2]), 32'h4);
    check("rr_win3", 32'(wins[3]), 32'h1);
    check("rr_len0", 32'(runs[0]), 32'd3);
    check("rr_len2", 32'(runs[2]), 32'd3);
    check("rr_no_timeout", 32'(tmo_seen), 32'h0);

    // Lone requester never releasing: forced release after MH cycles, then regranted.
    do_reset();
    for (int i = 0; i < 34; i++) cycle(3'b010, '0);
    check("hold_len", 32'(runs[0]), 32'(MH));
    check("hold_timeouts", 32'(tmo_seen), 32'h1);
    check("hold_regrant", 32'(wins.size()), 32'h2);

    // done coincides with the last allowed cycle: no timeout.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(3'b001, (m_own >= 0 && m_cnt == MH - 1) ? own_bit() : '0);
    check("edge_done_len", 32'(runs[0]), 32'(MH));
    check("edge_done_no_timeout", 32'(tmo_seen), 32'h0);

    // Non-owner activity is ignored; owner abandon hands over to requester 1.
    do_reset();
    for (int i = 0; i < 6; i++) cycle({1'b0, i[0], 1'b1}, {1'b0, ~i[0], 1'b0});
    for (int i = 0; i < 4; i++) cycle(3'b010, '0);
    check("abandon_win0", 32'(wins[0]), 32'h1);
    check("abandon_len0", 32'(runs[0]), 32'd5);
    check("abandon_win1", 32'(wins[1]), 32'h2);

    // Reset in the middle of ownership by requester 2.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(3'b100, '0);
    check("pre_reset_grant", 32'(grant), 32'h4);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_owner", 32'(owner), 32'h0);
    check("async_rst_timeout", 32'(timeout), 32'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    clear_obs();
    for (int i = 0; i < 4; i++) cycle(3'b101, '0);
    check("post_reset_first", 32'(wins[0]), 32'h1);

    // Random traffic with starvation tracking.
    do_reset();
    for (int i = 0; i < N; i++) begin wait_c[i] = 0; max_wait[i] = 0; end
    starv_en = 1;
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      d = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(15) == 0) r[b] = ~r[b];
        if ($urandom_range(7) == 0) d[b] = 1'b1;
      end
      cycle(r, d);
    end
    starv_en = 0;
    for (int i = 0; i < N; i++)
      if (max_wait[i] > STARVE_BOUND) check("starvation", 32'(max_wait[i]), 32'(STARVE_BOUND));
      else check("starvation", 32'h0, 32'h0 + 32'(max_wait[i] > STARVE_BOUND));
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
